// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM encoding, flag indices.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_SHL = 3'b101;
    localparam logic [2:0] ALU_SHR = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } alu_state_t;

    // Bit positions of the flags once they are packed into a status register.
    localparam int FLAG_Z    = 0;
    localparam int FLAG_N    = 1;
    localparam int FLAG_OVR  = 2;
    localparam int FLAG_COUT = 3;

endpackage

// File: rtl/alu_addsub.sv
// Ripple-carry adder/subtractor; sub=1 computes a + ~b + 1.
// Latency: combinational.
// Backpressure: none.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovr
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_eff;

    assign b_eff    = sub ? ~b : b;
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b_eff[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign cout = carry[WIDTH];
    assign ovr  = carry[WIDTH] ^ carry[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; shift-add multiplier for MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: result and flags hold in DONE until out_ready; in_ready only in IDLE.
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             N,
    output logic             OVR,
    output logic             Cout,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [SHW:0] MUL_STEPS = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE   = (SHW+1)'(1);

    alu_state_t state, state_nxt;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW:0]     cnt;

    logic             accept;
    logic             mul_last;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_sub, add_cout, add_ovr;

    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] acc_nxt, mplier_nxt;

    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   shl_ext, shr_ext;
    logic [WIDTH-1:0] op_res;
    logic             op_ovr, op_cout;

    assign accept   = in_valid && in_ready;
    assign mul_last = (state == ST_MUL_BUSY) && (cnt == CNT_ONE);

    // The single adder serves ADD/SUB in IDLE and the accumulator while multiplying.
    always_comb begin
        add_a   = A;
        add_b   = B;
        add_sub = (OP == ALU_SUB);
        if (state == ST_MUL_BUSY) begin
            add_a   = acc;
            add_b   = mcand;
            add_sub = 1'b0;
        end
    end

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout),
        .ovr  (add_ovr)
    );

    // Add-then-shift: {acc, mplier} shifts right as one register, so after
    // WIDTH steps acc holds the upper product half and mplier the lower.
    assign step_hi    = mplier[0] ? {add_cout, add_sum} : {1'b0, acc};
    assign acc_nxt    = step_hi[WIDTH:1];
    assign mplier_nxt = {step_hi[0], mplier[WIDTH-1:1]};

    // Shifts carry one extra bit so the last bit shifted out lands in it.
    assign shamt   = B[SHW-1:0];
    assign shl_ext = {1'b0, A} << shamt;
    assign shr_ext = {A, 1'b0} >> shamt;

    always_comb begin
        op_res  = '0;
        op_ovr  = 1'b0;
        op_cout = 1'b0;
        case (OP)
            ALU_ADD, ALU_SUB: begin
                op_res  = add_sum;
                op_ovr  = add_ovr;
                op_cout = add_cout;
            end
            ALU_AND: op_res = A & B;
            ALU_XOR: op_res = A ^ B;
            ALU_OR:  op_res = A | B;
            ALU_SHL: begin
                op_res  = shl_ext[WIDTH-1:0];
                op_cout = shl_ext[WIDTH];
            end
            ALU_SHR: begin
                op_res  = shr_ext[WIDTH:1];
                op_cout = shr_ext[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    state_nxt = (OP == ALU_MUL) ? ST_MUL_BUSY : ST_DONE;
                end
            end
            ST_MUL_BUSY: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Result and flags only change on the way into DONE, so they stay stable
    // through backpressure and keep their last value in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            R      <= '0;
            Z      <= 1'b0;
            N      <= 1'b0;
            OVR    <= 1'b0;
            Cout   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            if (accept) begin
                if (OP == ALU_MUL) begin
                    mcand  <= A;
                    mplier <= B;
                    acc    <= '0;
                    cnt    <= MUL_STEPS;
                end else begin
                    R    <= op_res;
                    Z    <= (op_res == '0);
                    N    <= op_res[WIDTH-1];
                    OVR  <= op_ovr;
                    Cout <= op_cout;
                end
            end
            if (state == ST_MUL_BUSY) begin
                acc    <= acc_nxt;
                mplier <= mplier_nxt;
                cnt    <= cnt - 1'b1;
            end
            if (mul_last) begin
                R    <= mplier_nxt;
                Z    <= (mplier_nxt == '0);
                N    <= mplier_nxt[WIDTH-1];
                OVR  <= |acc_nxt;
                Cout <= 1'b0;
            end
        end
    end

endmodule
